// File: rtl/gate_share_pkg.sv
// gate_share_pkg
// Shared definitions for the gate_share_arb slice:
//   state_e  - arbiter FSM states (IDLE, EXEC, RESP)
//   OP_*     - two-bit per-requester op codes
//   CNT_W    - width of the completed-operation counter
package gate_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int CNT_W = 8;

endpackage

// File: rtl/gate_share_rr.sv
// gate_share_rr
// Combinational round-robin picker. Scans req starting at ptr, moving
// upward and wrapping from NREQ-1 to 0; the first set bit wins.
// Ports:
//   req    [NREQ-1:0] in  - request vector
//   ptr    [IW-1:0]   in  - index where the search starts
//   winner [IW-1:0]   out - index of the winning requester (0 when none)
//   valid             out - high when any request is set
module gate_share_rr
  import gate_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Rotating priority scan; once valid is set later candidates are masked.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s  = IW'((int'(ptr) + k) % NREQ);
      hit_s  = req[idx_s] & ~valid;
      winner = hit_s ? idx_s : winner;
      valid  = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/gate_share_arb.sv
// gate_share_arb
// Time-shares one small logic unit between NREQ requesters. A round-robin
// pick in IDLE captures the winner's operands, EXEC evaluates them and RESP
// returns the result with a one-cycle done pulse.
// Optional feature: define GATE_SHARE_ARB_OPSEL_EN to let op select
// AND/OR/XOR/NAND per requester; otherwise the function is fixed AND and
// op is left unused.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req  [NREQ-1:0]     - per-requester request, held until its done
//   a, b [NREQ-1:0]     - per-requester one-bit operands
//   op   [2*NREQ-1:0]   - per-requester op code, bits [2i+1:2i]
//   gnt  [NREQ-1:0]     - one-hot grant, high in EXEC
//   done [NREQ-1:0]     - one-hot completion pulse, high in RESP
//   y                   - result, valid with done, 0 otherwise
//   busy                - high in EXEC and RESP
//   ops_cnt [CNT_W-1:0] - completed operations, wraps
module gate_share_arb
  import gate_share_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   a,
  input  logic [NREQ-1:0]   b,
  input  logic [2*NREQ-1:0] op,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              y,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_e            state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     win_r;
  logic              a_r;
  logic              b_r;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   done_r;
  logic              y_r;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [IW-1:0]     pick_s;
  logic              pick_valid_s;
  logic [IW-1:0]     nxt_ptr_s;
  logic              result_s;

`ifdef GATE_SHARE_ARB_OPSEL_EN
  logic [1:0]        op_r;

  function automatic logic eval_op(input logic av, input logic bv, input logic [1:0] opv);
    logic res;
    case (opv)
      OP_AND:  res = av & bv;
      OP_OR:   res = av | bv;
      OP_XOR:  res = av ^ bv;
      OP_NAND: res = ~(av & bv);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Selected function of the captured operands.
  always_comb begin
    result_s = eval_op(a_r, b_r, op_r);
  end
`else
  // op has no effect in this build; folding it into an unused net keeps it visible.
  logic unused_op_s;
  assign unused_op_s = ^op;

  // Fixed AND of the captured operands.
  always_comb begin
    result_s = a_r & b_r;
  end
`endif

  gate_share_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_r),
    .winner (pick_s),
    .valid  (pick_valid_s)
  );

  // Pointer moves to the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    if (int'(pick_s) == NREQ - 1) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = pick_s + 1'b1;
    end
  end

  // FSM, operand capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      win_r   <= '0;
      a_r     <= 1'b0;
      b_r     <= 1'b0;
`ifdef GATE_SHARE_ARB_OPSEL_EN
      op_r    <= 2'b00;
`endif
      gnt_r   <= '0;
      done_r  <= '0;
      y_r     <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= '0;
          y_r    <= 1'b0;
          if (pick_valid_s) begin
            state_r <= EXEC;
            win_r   <= pick_s;
            a_r     <= a[pick_s];
            b_r     <= b[pick_s];
`ifdef GATE_SHARE_ARB_OPSEL_EN
            op_r    <= op[{pick_s, 1'b0} +: 2];
`endif
            ptr_r   <= nxt_ptr_s;
            gnt_r   <= ONE_HOT0 << pick_s;
            busy_r  <= 1'b1;
          end else begin
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        EXEC: begin
          // Count at the same edge that raises done so both appear together in RESP.
          state_r <= RESP;
          gnt_r   <= '0;
          done_r  <= ONE_HOT0 << win_r;
          y_r     <= result_s;
          busy_r  <= 1'b1;
          cnt_r   <= cnt_r + 8'd1;
        end
        RESP: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          done_r  <= '0;
          y_r     <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          done_r  <= '0;
          y_r     <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign y       = y_r;
  assign busy    = busy_r;
  assign ops_cnt = cnt_r;

endmodule
